// File: rtl/writeback_stage.sv
// WB stage of the RV32I pipeline: MEM/WB register, load alignment/extension, register file write port.
// Optional WB_BYPASS_EN adds fwd_valid/fwd_rd/fwd_data copies of the write port for decode forwarding.
module writeback_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic             m_reg_write,
    input  logic [4:0]       m_rd,
    input  logic [1:0]       m_result_src,
    input  logic [31:0]      m_alu_result,
    input  logic [31:0]      m_read_data,
    input  logic [31:0]      m_pc_plus4,
    input  logic [2:0]       m_funct3,
    input  logic             hold,
    input  logic             flush,
    output logic             WE3,
    output logic [4:0]       A3,
    output logic [31:0]      WD3,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             load_err
`ifdef WB_BYPASS_EN
    ,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data
`endif
);

    // Handshake: an entry moves from MEM into WB on a posedge where m_valid and m_ready
    // are both high and flush is low; m_ready drops only while a held entry occupies WB.
    logic        wb_valid;
    logic        written;
    logic        reg_write_q;
    logic [4:0]  rd_q;
    logic [1:0]  result_src_q;
    logic [31:0] alu_result_q;
    logic [31:0] read_data_q;
    logic [31:0] pc_plus4_q;
    logic [2:0]  funct3_q;

    logic [1:0]  sel;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] result;
    logic        misaligned;
    logic        first_cycle;

    assign m_ready     = !hold || !wb_valid;
    assign sel         = alu_result_q[1:0];
    assign first_cycle = wb_valid && !written;

    always_comb begin
        byte_sel  = read_data_q[7:0];
        half_sel  = sel[1] ? read_data_q[31:16] : read_data_q[15:0];
        load_data = 32'd0;
        case (sel)
            2'd0: byte_sel = read_data_q[7:0];
            2'd1: byte_sel = read_data_q[15:8];
            2'd2: byte_sel = read_data_q[23:16];
            2'd3: byte_sel = read_data_q[31:24];
            default: byte_sel = read_data_q[7:0];
        endcase
        case (funct3_q)
            3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100: load_data = {24'd0, byte_sel};
            3'b001: load_data = {{16{half_sel[15]}}, half_sel};
            3'b101: load_data = {16'd0, half_sel};
            3'b010: load_data = read_data_q;
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        result     = alu_result_q;
        misaligned = 1'b0;
        case (result_src_q)
            2'b01: result = load_data;
            2'b10: result = pc_plus4_q;
            default: result = alu_result_q;
        endcase
        // Only loads can be misaligned; illegal load widths are treated the same way.
        if (result_src_q == 2'b01) begin
            case (funct3_q)
                3'b001, 3'b101: misaligned = sel[0];
                3'b010:         misaligned = (sel != 2'd0);
                3'b011, 3'b110, 3'b111: misaligned = 1'b1;
                default:        misaligned = 1'b0;
            endcase
        end
    end

    assign WE3 = first_cycle && reg_write_q && (rd_q != 5'd0) && !misaligned;
    assign A3  = wb_valid ? rd_q : 5'd0;
    assign WD3 = wb_valid ? result : 32'd0;

`ifdef WB_BYPASS_EN
    assign fwd_valid = WE3;
    assign fwd_rd    = A3;
    assign fwd_data  = WD3;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            written      <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= 5'd0;
            result_src_q <= 2'd0;
            alu_result_q <= 32'd0;
            read_data_q  <= 32'd0;
            pc_plus4_q   <= 32'd0;
            funct3_q     <= 3'd0;
            retire_cnt   <= '0;
            load_err     <= 1'b0;
        end else begin
            if (first_cycle) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
            if (first_cycle && misaligned) begin
                load_err <= 1'b1;
            end
            if (wb_valid) begin
                written <= 1'b1;
            end
            // Flush wins over capture; a new capture overrides the written mark above.
            if (flush) begin
                wb_valid <= 1'b0;
            end else if (m_ready) begin
                if (m_valid) begin
                    wb_valid     <= 1'b1;
                    written      <= 1'b0;
                    reg_write_q  <= m_reg_write;
                    rd_q         <= m_rd;
                    result_src_q <= m_result_src;
                    alu_result_q <= m_alu_result;
                    read_data_q  <= m_read_data;
                    pc_plus4_q   <= m_pc_plus4;
                    funct3_q     <= m_funct3;
                end else begin
                    wb_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reference model of expected register-file writes plus literal checks.
module tb_writeback_stage;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [2:0]  f3;
    } ent_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        int          due;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        m_valid;
    logic        m_ready;
    logic        m_reg_write;
    logic [4:0]  m_rd;
    logic [1:0]  m_result_src;
    logic [31:0] m_alu_result;
    logic [31:0] m_read_data;
    logic [31:0] m_pc_plus4;
    logic [2:0]  m_funct3;
    logic        hold;
    logic        flush;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] retire_cnt;
    logic        load_err;
    logic        m_ready4;
    logic        we3_4;
    logic [4:0]  a3_4;
    logic [31:0] wd3_4;
    logic [3:0]  retire_cnt4;
    logic        load_err4;
`ifdef WB_BYPASS_EN
    logic        fwd_valid, fwd_valid4;
    logic [4:0]  fwd_rd, fwd_rd4;
    logic [31:0] fwd_data, fwd_data4;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   exp_retire = 0;
    logic exp_err = 1'b0;
    wr_t  exp_q[$];

    writeback_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready),
        .m_reg_write(m_reg_write), .m_rd(m_rd), .m_result_src(m_result_src),
        .m_alu_result(m_alu_result), .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
        .m_funct3(m_funct3), .hold(hold), .flush(flush),
        .WE3(we3), .A3(a3), .WD3(wd3), .retire_cnt(retire_cnt), .load_err(load_err)
`ifdef WB_BYPASS_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );

    writeback_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready4),
        .m_reg_write(m_reg_write), .m_rd(m_rd), .m_result_src(m_result_src),
        .m_alu_result(m_alu_result), .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
        .m_funct3(m_funct3), .hold(hold), .flush(flush),
        .WE3(we3_4), .A3(a3_4), .WD3(wd3_4), .retire_cnt(retire_cnt4), .load_err(load_err4)
`ifdef WB_BYPASS_EN
        , .fwd_valid(fwd_valid4), .fwd_rd(fwd_rd4), .fwd_data(fwd_data4)
`endif
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: value the instruction architecturally writes
    function automatic logic [31:0] model_data(input ent_t e);
        logic [31:0] w;
        logic [31:0] h;
        int sel;
        sel = int'(e.alu[1:0]);
        w = e.rdata >> (8 * sel);
        h = e.rdata >> (16 * (sel / 2));
        if (e.src == 2'b10) return e.pc;
        if (e.src != 2'b01) return e.alu;
        case (e.f3)
            3'd0: return {{24{w[7]}}, w[7:0]};
            3'd4: return {24'd0, w[7:0]};
            3'd1: return {{16{h[15]}}, h[15:0]};
            3'd5: return {16'd0, h[15:0]};
            3'd2: return e.rdata;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_mis(input ent_t e);
        int sel;
        sel = int'(e.alu[1:0]);
        if (e.src != 2'b01) return 1'b0;
        if (e.f3 == 3'd3 || e.f3 == 3'd6 || e.f3 == 3'd7) return 1'b1;
        if ((e.f3 == 3'd1 || e.f3 == 3'd5) && (sel % 2 == 1)) return 1'b1;
        if (e.f3 == 3'd2 && sel != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic ent_t mk(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                                input logic [31:0] alu, input logic [31:0] rdata, input logic [2:0] f3);
        ent_t e;
        e.rw = rw; e.rd = rd; e.src = src; e.alu = alu; e.rdata = rdata;
        e.pc = alu + 32'h100; e.f3 = f3;
        return e;
    endfunction

    // driver: apply one cycle of inputs, record accepted entries in the model
    task automatic step(input ent_t e, input logic v, input logic h, input logic fl, output logic rdy);
        @(posedge clk);
        #1;
        m_valid = v; m_reg_write = e.rw; m_rd = e.rd; m_result_src = e.src;
        m_alu_result = e.alu; m_read_data = e.rdata; m_pc_plus4 = e.pc; m_funct3 = e.f3;
        hold = h; flush = fl;
        #1;
        rdy = m_ready;
        if (v && rdy && !fl) begin
            exp_retire++;
            if (model_mis(e)) exp_err = 1'b1;
            if (e.rw && e.rd != 5'd0 && !model_mis(e))
                exp_q.push_back('{rd: e.rd, data: model_data(e), due: cyc + 1});
        end
    endtask

    task automatic idle(input int n);
        logic r;
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0, r);
    endtask

    task automatic check_state(input string tag);
        idle(2);
        chk({tag, "_retire"}, retire_cnt, 32'(exp_retire));
        chk({tag, "_retire4"}, {28'd0, retire_cnt4}, 32'(exp_retire % 16));
        chk({tag, "_load_err"}, {31'd0, load_err}, {31'd0, exp_err});
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // compare process: every write must match the model in content and timing
    always @(negedge clk) begin
        if (we3) begin
            if (exp_q.size() == 0) begin
                chk("spurious_we3", {27'd0, a3}, 32'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_a3", {27'd0, a3}, {27'd0, w.rd});
                chk("wr_wd3", wd3, w.data);
                chk("wr_cycle", 32'(cyc), 32'(w.due));
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            wr_t w;
            w = exp_q.pop_front();
            chk("missing_we3", {31'd0, we3}, 32'd1);
        end
`ifdef WB_BYPASS_EN
        chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, we3});
        chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, a3});
        chk("fwd_data", fwd_data, wd3);
`endif
    end

    initial begin
        ent_t e;
        logic r;
        logic [2:0] f3_tab[8];
        f3_tab = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};

        rst = 1'b0; m_valid = 0; m_reg_write = 0; m_rd = 0; m_result_src = 0;
        m_alu_result = 0; m_read_data = 0; m_pc_plus4 = 0; m_funct3 = 0; hold = 0; flush = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we3", {31'd0, we3}, 32'd0);
        chk("rst_a3", {27'd0, a3}, 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_m_ready", {31'd0, m_ready}, 32'd1);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        rst = 1'b1;

        // model pins
        chk("model_lb", model_data(mk(1, 1, 2'b01, 32'h3, 32'h80FF_7F01, 3'd0)), 32'hFFFF_FF80);
        chk("model_lhu", model_data(mk(1, 1, 2'b01, 32'h2, 32'h80FF_7F01, 3'd5)), 32'h0000_80FF);
        chk("model_lw_mis", {31'd0, model_mis(mk(1, 1, 2'b01, 32'h2, 32'h0, 3'd2))}, 32'd1);

        // ALU op: write visible one cycle after capture
        step(mk(1, 5, 2'b00, 32'h1234_5678, 32'h0, 3'd0), 1, 0, 0, r);
        idle(1);
        chk("alu_we3", {31'd0, we3}, 32'd1);
        chk("alu_a3", {27'd0, a3}, 32'd5);
        chk("alu_wd3", wd3, 32'h1234_5678);
        idle(1);
        chk("alu_retire", retire_cnt, 32'd1);

        // loads with hand-computed data
        step(mk(1, 10, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 3'd0), 1, 0, 0, r);
        idle(1);
        chk("lb_wd3", wd3, 32'hFFFF_FF80);
        step(mk(1, 11, 2'b01, 32'h0000_1002, 32'h80FF_7F01, 3'd5), 1, 0, 0, r);
        idle(1);
        chk("lhu_wd3", wd3, 32'h0000_80FF);
        step(mk(1, 12, 2'b10, 32'h0000_2000, 32'h0, 3'd0), 1, 0, 0, r);
        step(mk(1, 13, 2'b11, 32'hCAFE_0001, 32'h0, 3'd0), 1, 0, 0, r);
        step(mk(0, 14, 2'b00, 32'h1111_1111, 32'h0, 3'd0), 1, 0, 0, r);
        check_state("aligned");
        chk("aligned_err_lit", {31'd0, load_err}, 32'd0);

        // misaligned LW and rd=0
        step(mk(1, 15, 2'b01, 32'h0000_3002, 32'hDEAD_BEEF, 3'd2), 1, 0, 0, r);
        step(mk(1, 0, 2'b00, 32'h5555_5555, 32'h0, 3'd0), 1, 0, 0, r);
        check_state("mis");
        chk("mis_err_lit", {31'd0, load_err}, 32'd1);

        // back-to-back sweep of every load width over every byte offset
        for (int i = 0; i < 32; i++) begin
            e = mk(1, 5'(1 + i % 31), 2'b01, 32'h400 + 32'(i % 4),
                   32'hA1B2_C3D4 ^ (32'h0101_0101 * 32'(i)), f3_tab[i / 4]);
            step(e, 1, 0, 0, r);
        end
        check_state("sweep");

        // hold: one write, m_ready low while frozen, next entry accepted on release
        step(mk(1, 7, 2'b00, 32'h0707_0707, 32'h0, 3'd0), 1, 1, 0, r);
        chk("hold_capture_ready", {31'd0, r}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(mk(1, 8, 2'b00, 32'h0808_0808, 32'h0, 3'd0), 1, 1, 0, r);
            chk("hold_m_ready", {31'd0, r}, 32'd0);
        end
        step(mk(1, 8, 2'b00, 32'h0808_0808, 32'h0, 3'd0), 1, 0, 0, r);
        chk("release_m_ready", {31'd0, r}, 32'd1);
        check_state("hold");

        // flush with a simultaneous offer: current entry still writes, offer is dropped
        step(mk(1, 20, 2'b00, 32'h2020_2020, 32'h0, 3'd0), 1, 0, 0, r);
        step(mk(1, 21, 2'b00, 32'h2121_2121, 32'h0, 3'd0), 1, 0, 1, r);
        idle(1);
        chk("flush_a3", {27'd0, a3}, 32'd0);
        check_state("flush");

        // reset during hold
        step(mk(1, 9, 2'b00, 32'h0909_0909, 32'h0, 3'd0), 1, 1, 0, r);
        step('0, 0, 1, 0, r);
        step('0, 0, 1, 0, r);
        rst = 1'b0;
        #1;
        chk("rsth_we3", {31'd0, we3}, 32'd0);
        chk("rsth_a3", {27'd0, a3}, 32'd0);
        chk("rsth_wd3", wd3, 32'd0);
        chk("rsth_retire", retire_cnt, 32'd0);
        chk("rsth_load_err", {31'd0, load_err}, 32'd0);
        chk("rsth_m_ready", {31'd0, m_ready}, 32'd1);
        exp_retire = 0; exp_err = 1'b0; exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step('0, 0, 1, 0, r);
        check_state("post_rst");

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) step(mk(1, 5'(i + 1), 2'b00, 32'(i * 3), 32'h0, 3'd0), 1, 0, 0, r);
        check_state("wrap");
        chk("wrap_lit4", {28'd0, retire_cnt4}, 32'd1);
        chk("wrap_lit32", retire_cnt, 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
